// File: rtl/gpu_pkg.sv
// Shared types and default constants for the kernel-launch dispatcher.
//   dispatch_state_t           : top-level sequencing states
//   DEFAULT_TC_W               : default width of thread counts and block IDs
//   DEFAULT_THREADS_PER_BLOCK  : default block size (power of two)
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } dispatch_state_t;

    localparam int DEFAULT_TC_W              = 8;
    localparam int DEFAULT_THREADS_PER_BLOCK = 4;

endpackage

// File: rtl/gpu_dispatcher_lowest_idle_picker.sv
// Combinational priority encoder: finds the lowest-index idle core.
//   idle  : one bit per core, 1 = core can accept a block
//   valid : at least one core is idle
//   idx   : index of the lowest-numbered idle core (0 when none)
module lowest_idle_picker
    import gpu_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_CORES-1:0] idle,
    output logic                 valid,
    output logic [IDX_W-1:0]     idx
);

    // Scanning from the top down lets the lowest idle index win.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (idle[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/gpu_dispatcher.sv
// Kernel-launch front end: splits a launch into fixed-size blocks, hands
// them to idle cores one per cycle and reports completion.
//   clk, reset        : clock, synchronous active-high reset
//   start             : launch request (sampled in IDLE); also holds DONE
//   thread_count      : total threads of the launch
//   core_start        : per-core one-cycle dispatch pulse
//   core_block_id     : per-core block index, core i at [i*TC_W +: TC_W]
//   core_thread_count : per-core active threads in its block, same packing
//   core_done         : per-core one-cycle retire pulse
//   done              : all blocks retired; held until start is low
module gpu_dispatcher
    import gpu_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = DEFAULT_THREADS_PER_BLOCK,
    parameter int TC_W              = DEFAULT_TC_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [TC_W-1:0]           thread_count,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [NUM_CORES*TC_W-1:0] core_block_id,
    output logic [NUM_CORES*TC_W-1:0] core_thread_count,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic                      done
);

    localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    // One extra bit so block counts never wrap.
    localparam int CNT_W    = TC_W + 1;

    dispatch_state_t      state_reg;
    logic [TC_W-1:0]      tc_reg;
    logic [CNT_W-1:0]     total_reg;
    logic [CNT_W-1:0]     dispatched_reg;
    logic [CNT_W-1:0]     retired_reg;
    logic [NUM_CORES-1:0] busy_reg;
    logic [NUM_CORES-1:0] core_start_reg;
    logic [TC_W-1:0]      block_id_reg  [NUM_CORES];
    logic [TC_W-1:0]      block_cnt_reg [NUM_CORES];
    logic                 done_reg;

    logic [NUM_CORES-1:0] idle_vec;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic                 dispatch_now;
    logic [NUM_CORES-1:0] pick_onehot;
    logic [CNT_W-1:0]     total_next;
    logic [TC_W-1:0]      last_cnt;
    logic [TC_W-1:0]      blk_cnt_next;
    logic [NUM_CORES-1:0] retire_mask;
    logic [CNT_W-1:0]     retire_cnt;

    // Dispatch choice uses the registered busy vector, so a core retiring
    // this cycle is only eligible again next cycle.
    assign idle_vec = ~busy_reg;

    lowest_idle_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .idle  (idle_vec),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Ceiling division of the thread count by the block size.
    assign total_next   = (CNT_W'(thread_count) + CNT_W'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB;
    // Threads left over for the final block (1..THREADS_PER_BLOCK).
    assign last_cnt     = tc_reg - TC_W'((total_reg - CNT_W'(1)) << LOG2_TPB);
    assign blk_cnt_next = (dispatched_reg == total_reg - CNT_W'(1)) ? last_cnt
                                                                   : TC_W'(THREADS_PER_BLOCK);
    assign dispatch_now = (state_reg == RUN) && pick_valid && (dispatched_reg < total_reg);
    assign pick_onehot  = dispatch_now ? (NUM_CORES'(1) << pick_idx) : '0;

    // Retire pulses on idle cores are spurious and dropped here.
    assign retire_mask = core_done & busy_reg;

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            retire_cnt = retire_cnt + CNT_W'(retire_mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            tc_reg         <= '0;
            total_reg      <= '0;
            dispatched_reg <= '0;
            retired_reg    <= '0;
            busy_reg       <= '0;
            core_start_reg <= '0;
            done_reg       <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                block_id_reg[i]  <= '0;
                block_cnt_reg[i] <= '0;
            end
        end else begin
            core_start_reg <= '0;
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        tc_reg         <= thread_count;
                        total_reg      <= total_next;
                        dispatched_reg <= '0;
                        retired_reg    <= '0;
                        busy_reg       <= '0;
                        if (total_next == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (retired_reg == total_reg) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        retired_reg <= retired_reg + retire_cnt;
                        busy_reg    <= (busy_reg & ~core_done) | pick_onehot;
                        if (dispatch_now) begin
                            core_start_reg[pick_idx] <= 1'b1;
                            block_id_reg[pick_idx]   <= dispatched_reg[TC_W-1:0];
                            block_cnt_reg[pick_idx]  <= blk_cnt_next;
                            dispatched_reg           <= dispatched_reg + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign core_start = core_start_reg;
    assign done       = done_reg;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_pack
            assign core_block_id[gi*TC_W +: TC_W]     = block_id_reg[gi];
            assign core_thread_count[gi*TC_W +: TC_W] = block_cnt_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_gpu_dispatcher.sv
// Self-checking bench for gpu_dispatcher: hand-derived launch table,
// randomized launches against a block-level reference model, and hand
// sequences for reset, held start and spurious retire pulses.
module tb_gpu_dispatcher;
    import gpu_pkg::*;

    localparam int NC    = 2;
    localparam int TPB   = 4;
    localparam int TW    = 8;
    localparam int LIMIT = 2000;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [TW-1:0]  thread_count;
    logic [NC-1:0]  core_start;
    logic [NC*TW-1:0] core_block_id;
    logic [NC*TW-1:0] core_thread_count;
    logic [NC-1:0]  core_done;
    logic           done;

    always #5 clk = ~clk;

    gpu_dispatcher #(
        .NUM_CORES         (NC),
        .THREADS_PER_BLOCK (TPB),
        .TC_W              (TW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_start        (core_start),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .core_done         (core_done),
        .done              (done)
    );

    int checks = 0;
    int errors = 0;
    // Expected block id / thread count currently held by each core.
    int exp_id  [NC];
    int exp_cnt [NC];

    typedef struct {
        int tc;
        int lat0;
        int lat1;
        int blocks;
        int last_cnt;
        int last_core;
        int done_cycle;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " core_start"}, int'(core_start), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " core_block_id"}, int'(core_block_id), 0);
        chk({tag, " core_thread_count"}, int'(core_thread_count), 0);
    endtask

    // Runs one launch with cores that retire lat cycles after their start
    // pulse. Cycle c is observed 1 time unit after the c-th edge following
    // the start request; edge 0 accepts the launch.
    task automatic run_launch(input int tc, input int lat0, input int lat1, input bit spurious,
                              output int n_blocks, output int last_cnt,
                              output int last_core, output int done_cycle);
        int total, next_blk, retired, done_edge, c, exp_pick;
        int lat [NC];
        int cnt_r [NC];
        bit model_idle [NC];
        bit new_idle [NC];
        bit rbusy [NC];
        bit done_prev [NC];

        total     = (tc + TPB - 1) / TPB;
        lat[0]    = lat0;
        lat[1]    = lat1;
        next_blk  = 0;
        retired   = 0;
        done_edge = (total == 0) ? 0 : -1;
        n_blocks  = 0;
        last_cnt  = 0;
        last_core = -1;
        done_cycle = -1;
        for (int i = 0; i < NC; i++) begin
            model_idle[i] = 1'b1;
            rbusy[i]      = 1'b0;
            done_prev[i]  = 1'b0;
            cnt_r[i]      = 0;
        end
        start        = 1'b1;
        thread_count = TW'(tc);
        core_done    = '0;
        c = -1;

        while (done_cycle < 0 && c < LIMIT) begin
            tick();
            c++;
            thread_count = TW'($urandom);   // must be ignored once launched

            // Blocks go out in order, one per cycle, to the lowest idle core.
            exp_pick = -1;
            if (c >= 1 && next_blk < total) begin
                for (int i = NC - 1; i >= 0; i--) begin
                    if (model_idle[i]) exp_pick = i;
                end
            end
            for (int i = 0; i < NC; i++) begin
                chk($sformatf("core_start[%0d] tc=%0d cyc=%0d", i, tc, c),
                    int'(core_start[i]), (i == exp_pick) ? 1 : 0);
            end
            if (exp_pick >= 0) begin
                exp_id[exp_pick]  = next_blk;
                exp_cnt[exp_pick] = (tc - next_blk * TPB > TPB) ? TPB : tc - next_blk * TPB;
                next_blk++;
            end
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    n_blocks++;
                    last_core = i;
                    last_cnt  = int'(core_thread_count[i*TW +: TW]);
                end
                chk($sformatf("block_id[%0d] tc=%0d cyc=%0d", i, tc, c),
                    int'(core_block_id[i*TW +: TW]), exp_id[i]);
                chk($sformatf("thread_cnt[%0d] tc=%0d cyc=%0d", i, tc, c),
                    int'(core_thread_count[i*TW +: TW]), exp_cnt[i]);
            end

            // Retires sampled at this edge; only busy cores count.
            for (int i = 0; i < NC; i++) new_idle[i] = model_idle[i] && (i != exp_pick);
            for (int i = 0; i < NC; i++) begin
                if (done_prev[i] && !model_idle[i]) begin
                    retired++;
                    new_idle[i] = 1'b1;
                end
            end
            model_idle = new_idle;
            if (total > 0 && retired == total && done_edge < 0) done_edge = c + 1;

            chk($sformatf("done tc=%0d cyc=%0d", tc, c), int'(done),
                (done_edge >= 0 && c >= done_edge) ? 1 : 0);
            if (done) done_cycle = c;

            // Core responders.
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    rbusy[i] = 1'b1;
                    cnt_r[i] = lat[i];
                end
                if (rbusy[i]) begin
                    if (cnt_r[i] <= 1) begin
                        done_prev[i] = 1'b1;
                        rbusy[i]     = 1'b0;
                    end else begin
                        cnt_r[i]--;
                        done_prev[i] = 1'b0;
                    end
                end else begin
                    done_prev[i] = spurious && ($urandom_range(0, 5) == 0);
                end
                core_done[i] = done_prev[i];
            end
        end
        if (done_cycle < 0) chk($sformatf("done timeout tc=%0d", tc), 0, 1);

        // start held high: stay in DONE, no relaunch.
        core_done = '0;
        repeat (2) begin
            tick();
            chk($sformatf("done held tc=%0d", tc), int'(done), 1);
            chk($sformatf("no relaunch tc=%0d", tc), int'(core_start), 0);
        end
        start = 1'b0;
        tick();
        chk($sformatf("done drop tc=%0d", tc), int'(done), 0);
        tick();
        chk($sformatf("idle quiet tc=%0d", tc), int'(core_start) + int'(done), 0);
        $display("launch tc=%0d lat=%0d/%0d: blocks=%0d last_cnt=%0d last_core=%0d done_cycle=%0d",
                 tc, lat0, lat1, n_blocks, last_cnt, last_core, done_cycle);
    endtask

    initial begin
        int nb, lc, lcore, dc, tc, total;

        // tc, lat0, lat1 | blocks, last_cnt, last_core, done_cycle
        vecs[0] = '{8,   1, 1,  2,  4,  1,  4};
        vecs[1] = '{10,  1, 1,  3,  2,  0,  5};
        vecs[2] = '{0,   1, 1,  0,  0, -1,  0};
        vecs[3] = '{1,   3, 3,  1,  1,  0,  5};
        vecs[4] = '{16,  2, 5,  4,  4,  0, 10};
        vecs[5] = '{255, 1, 1, 64,  3,  1, 66};
        vecs[6] = '{5,   4, 1,  2,  1,  1,  6};
        vecs[7] = '{16,  3, 20, 4,  4,  0, 23};

        for (int i = 0; i < NC; i++) begin
            exp_id[i]  = 0;
            exp_cnt[i] = 0;
        end
        reset        = 1'b1;
        start        = 1'b0;
        thread_count = '0;
        core_done    = '0;
        repeat (2) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // Spurious retire pulses while idle are ignored.
        core_done = '1;
        tick();
        core_done = '0;
        chk("idle spurious core_start", int'(core_start), 0);
        chk("idle spurious done", int'(done), 0);

        for (int v = 0; v < 8; v++) begin
            run_launch(vecs[v].tc, vecs[v].lat0, vecs[v].lat1, 1'b0, nb, lc, lcore, dc);
            chk($sformatf("vec%0d blocks", v), nb, vecs[v].blocks);
            chk($sformatf("vec%0d last_cnt", v), lc, vecs[v].last_cnt);
            chk($sformatf("vec%0d last_core", v), lcore, vecs[v].last_core);
            chk($sformatf("vec%0d done_cycle", v), dc, vecs[v].done_cycle);
        end

        // Reset in the middle of a run, then a fresh launch.
        start        = 1'b1;
        thread_count = 8'd8;
        tick();
        tick();
        chk("mid-run first dispatch", int'(core_start), 1);
        reset = 1'b1;
        start = 1'b0;
        tick();
        chk_zero("mid-run reset");
        for (int i = 0; i < NC; i++) begin
            exp_id[i]  = 0;
            exp_cnt[i] = 0;
        end
        reset = 1'b0;
        tick();
        chk("post-reset done", int'(done), 0);
        chk("post-reset core_start", int'(core_start), 0);
        run_launch(4, 1, 1, 1'b0, nb, lc, lcore, dc);
        chk("post-reset blocks", nb, 1);
        chk("post-reset last_cnt", lc, 4);
        chk("post-reset last_core", lcore, 0);
        chk("post-reset done_cycle", dc, 3);

        // Randomized launches with spurious retire pulses on idle cores.
        for (int r = 0; r < 16; r++) begin
            tc    = (r % 4 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
            total = (tc + TPB - 1) / TPB;
            run_launch(tc, $urandom_range(1, 5), $urandom_range(1, 5), 1'b1, nb, lc, lcore, dc);
            chk($sformatf("rand%0d blocks", r), nb, total);
            if (total > 0) chk($sformatf("rand%0d last_cnt", r), lc, tc - (total - 1) * TPB);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
